// File: rtl/jtpopeye_inputs_pkg.sv
// Key codes and joystick bit layout shared by the cabinet input block.
// Key codes are {extended, code[7:0]}.
package jtpopeye_inputs_pkg;

   localparam int NKEYS    = 21;
   localparam int K_START0 = 16;
   localparam int K_COIN0  = 18;
   localparam int K_PAUSE  = 20;

   localparam logic [8:0] KC_P1_UP = 9'h175;
   localparam logic [8:0] KC_P1_DN = 9'h172;
   localparam logic [8:0] KC_P1_LF = 9'h16B;
   localparam logic [8:0] KC_P1_RT = 9'h174;
   localparam logic [8:0] KC_P1_B0 = 9'h014;
   localparam logic [8:0] KC_P1_B1 = 9'h011;
   localparam logic [8:0] KC_P1_B2 = 9'h029;
   localparam logic [8:0] KC_P1_B3 = 9'h012;
   localparam logic [8:0] KC_P2_UP = 9'h02D;
   localparam logic [8:0] KC_P2_DN = 9'h02B;
   localparam logic [8:0] KC_P2_LF = 9'h023;
   localparam logic [8:0] KC_P2_RT = 9'h034;
   localparam logic [8:0] KC_P2_B0 = 9'h01C;
   localparam logic [8:0] KC_P2_B1 = 9'h01B;
   localparam logic [8:0] KC_P2_B2 = 9'h015;
   localparam logic [8:0] KC_P2_B3 = 9'h01D;
   localparam logic [8:0] KC_START1 = 9'h005;
   localparam logic [8:0] KC_START2 = 9'h006;
   localparam logic [8:0] KC_COIN1  = 9'h004;
   localparam logic [8:0] KC_COIN2  = 9'h003;
   localparam logic [8:0] KC_PAUSE  = 9'h00C;

   // Key index p*8+j lines up with joystick bit j of player p (0 rt, 1 lf, 2 dn, 3 up, 4.. buttons).
   function automatic logic [8:0] key_code(input int k);
      logic [8:0] c;
      case (k)
         0:  c = KC_P1_RT;  1:  c = KC_P1_LF;  2:  c = KC_P1_DN;  3:  c = KC_P1_UP;
         4:  c = KC_P1_B0;  5:  c = KC_P1_B1;  6:  c = KC_P1_B2;  7:  c = KC_P1_B3;
         8:  c = KC_P2_RT;  9:  c = KC_P2_LF;  10: c = KC_P2_DN;  11: c = KC_P2_UP;
         12: c = KC_P2_B0;  13: c = KC_P2_B1;  14: c = KC_P2_B2;  15: c = KC_P2_B3;
         16: c = KC_START1; 17: c = KC_START2; 18: c = KC_COIN1;  19: c = KC_COIN2;
         default: c = KC_PAUSE;
      endcase
      return c;
   endfunction

   function automatic int jb_btn(input int b);   return 4 + b; endfunction
   function automatic int jb_start(input int nb); return 4 + nb; endfunction
   function automatic int jb_coin(input int nb);  return 5 + nb; endfunction
   function automatic int jb_pause(input int nb); return 6 + nb; endfunction

endpackage

// File: rtl/jtpopeye_coin_stretch.sv
// Stretches a coin request into a fixed-length active-low pulse; only a fresh
// press while idle starts a pulse.
module jtpopeye_coin_stretch #(
   parameter int COIN_CYCLES = 16384
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_req,
   output logic o_coin_n
);

   localparam int CW = $clog2(COIN_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_req_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_req_d <= 1'b0;
      end else begin
         // edge history tracks even through a clear so a held coin never retriggers
         r_req_d <= i_req;
         if (i_clr)
            r_cnt <= '0;
         else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
         else if (i_req && !r_req_d)
            r_cnt <= CW'(COIN_CYCLES);
      end
   end

   assign o_coin_n = (r_cnt == '0);

endmodule

// File: rtl/jtpopeye_cab_inputs.sv
// Cabinet inputs: merges PS/2 key events and HPS joysticks into active-low
// game controls with autofire, coin stretching and a pause toggle.
module jtpopeye_cab_inputs
   import jtpopeye_inputs_pkg::*;
#(
   parameter int PLAYERS     = 2,
   parameter int BUTTONS     = 1,
   parameter int COIN_CYCLES = 16384,
   parameter int AF_DIV      = 1048576
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_soft_rst,
   input  logic                          i_downloading,
   input  logic [10:0]                   i_ps2_key,
   input  logic [16*PLAYERS-1:0]         i_joystick,
   input  logic [BUTTONS-1:0]            i_autofire_en,
   output logic [PLAYERS*(4+BUTTONS)-1:0] o_joy_n,
   output logic [PLAYERS-1:0]            o_start_n,
   output logic [PLAYERS-1:0]            o_coin_n,
   output logic                          o_pause
);

   localparam int JW       = 4 + BUTTONS;
   localparam int AFW      = $clog2(AF_DIV);
   localparam int JB_START = jb_start(BUTTONS);
   localparam int JB_COIN  = jb_coin(BUTTONS);
   localparam int JB_PAUSE = jb_pause(BUTTONS);

   logic                         r_old_tgl, r_armed;
   logic [NKEYS-1:0]             r_key;
   logic [AFW-1:0]               r_af_cnt;
   logic                         r_af_phase;
   logic [PLAYERS-1:0][JW-1:0]   r_joy_n;
   logic [PLAYERS-1:0]           r_start_n;
   logic                         r_pause, r_pause_req_d;

   logic                         w_event, w_clr;
   logic [BUTTONS-1:0]           w_af;
   logic [PLAYERS-1:0][JW-1:0]   w_joy_req;
   logic [PLAYERS-1:0]           w_start_req, w_pause_js;
   logic                         w_pause_req;
   logic                         w_unused;

   assign w_event = r_armed && (i_ps2_key[10] != r_old_tgl);
   assign w_clr   = i_soft_rst || i_downloading;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_old_tgl <= 1'b0;
         r_armed   <= 1'b0;
         r_key     <= '0;
      end else begin
         r_old_tgl <= i_ps2_key[10];
         r_armed   <= 1'b1;
         if (w_clr)
            r_key <= '0;
         else if (w_event)
            for (int k = 0; k < NKEYS; k++)
               if (i_ps2_key[8:0] == key_code(k)) r_key[k] <= i_ps2_key[9];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_af_cnt   <= '0;
         r_af_phase <= 1'b0;
      end else if (r_af_cnt == AFW'(AF_DIV - 1)) begin
         r_af_cnt   <= '0;
         r_af_phase <= ~r_af_phase;
      end else begin
         r_af_cnt   <= r_af_cnt + 1'b1;
      end
   end

   assign w_af = ~i_autofire_en | {BUTTONS{r_af_phase}};

   for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
      logic w_coin_req;
      // the keyboard only drives the first two players
      if (p < 2) begin : g_key
         assign w_joy_req[p][3:0] = i_joystick[16*p +: 4] | r_key[8*p +: 4];
         for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
            assign w_joy_req[p][4+b] =
               (i_joystick[16*p + jb_btn(b)] | r_key[8*p + 4 + b]) & w_af[b];
         end
         assign w_start_req[p] = i_joystick[16*p + JB_START] | r_key[K_START0 + p];
         assign w_coin_req     = i_joystick[16*p + JB_COIN]  | r_key[K_COIN0 + p];
      end else begin : g_nokey
         assign w_joy_req[p][3:0] = i_joystick[16*p +: 4];
         for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
            assign w_joy_req[p][4+b] = i_joystick[16*p + jb_btn(b)] & w_af[b];
         end
         assign w_start_req[p] = i_joystick[16*p + JB_START];
         assign w_coin_req     = i_joystick[16*p + JB_COIN];
      end
      assign w_pause_js[p] = i_joystick[16*p + JB_PAUSE];

      jtpopeye_coin_stretch #(.COIN_CYCLES(COIN_CYCLES)) u_coin (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_clr    (i_downloading),
         .i_req    (w_coin_req),
         .o_coin_n (o_coin_n[p])
      );
   end

   assign w_pause_req = r_key[K_PAUSE] | (|w_pause_js);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_joy_n       <= '1;
         r_start_n     <= '1;
         r_pause       <= 1'b0;
         r_pause_req_d <= 1'b0;
      end else begin
         r_joy_n       <= i_downloading ? '1 : ~w_joy_req;
         r_start_n     <= i_downloading ? '1 : ~w_start_req;
         r_pause_req_d <= w_pause_req;
         if (w_clr)
            r_pause <= 1'b0;
         else if (w_pause_req && !r_pause_req_d)
            r_pause <= ~r_pause;
      end
   end

   assign o_joy_n   = r_joy_n;
   assign o_start_n = r_start_n;
   assign o_pause   = r_pause;

   // joystick bits above the pause bit and unmapped button keys are don't-cares
   assign w_unused = ^{i_joystick, r_key};

endmodule

// File: tb/tb_jtpopeye_cab_inputs.sv
// Directed bench for jtpopeye_cab_inputs with 2 players, 1 button, short coin and autofire periods.
module tb_jtpopeye_cab_inputs;

   localparam int P  = 2;
   localparam int B  = 1;
   localparam int CC = 16;
   localparam int AF = 4;

   logic          i_clk = 1'b0, i_rst = 1'b1, i_soft_rst = 1'b0, i_downloading = 1'b0;
   logic [10:0]   i_ps2_key = '0;
   logic [31:0]   i_joystick = '0;
   logic [0:0]    i_autofire_en = '0;
   logic [9:0]    o_joy_n;
   logic [1:0]    o_start_n, o_coin_n;
   logic          o_pause;

   jtpopeye_cab_inputs #(.PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(CC), .AF_DIV(AF)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_soft_rst(i_soft_rst), .i_downloading(i_downloading),
      .i_ps2_key(i_ps2_key), .i_joystick(i_joystick), .i_autofire_en(i_autofire_en),
      .o_joy_n(o_joy_n), .o_start_n(o_start_n), .o_coin_n(o_coin_n), .o_pause(o_pause)
   );

   always #5 i_clk = ~i_clk;

   int   n_tests = 0, n_fail = 0;
   logic tgl = 1'b0;

   typedef struct {
      logic [31:0] js;
      logic [9:0]  joy;
      logic [1:0]  st;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic key(input logic pr, input logic ext, input logic [7:0] code);
      tgl = ~tgl;
      i_ps2_key = {tgl, pr, ext, code};
   endtask

   // Counts coin_n[0] low cycles and falling edges over n cycles; optional re-press script.
   task automatic coin_run(input int n, input bit repress, output int low, output int pulses);
      logic prev = 1'b1;
      low = 0; pulses = 0;
      for (int i = 0; i < n; i++) begin
         if (repress && i == 4) i_joystick[6] = 1'b0;
         if (repress && i == 8) i_joystick[6] = 1'b1;
         cyc(1);
         if (!o_coin_n[0]) low++;
         if (prev && !o_coin_n[0]) pulses++;
         prev = o_coin_n[0];
      end
   endtask

   initial begin
      logic s[16];
      int   trans, low, pulses;
      bit   ok;

      tbl[0] = '{32'h0000_0000, 10'h3FF, 2'b11};
      tbl[1] = '{32'h0000_0008, 10'h3F7, 2'b11};
      tbl[2] = '{32'h0000_0011, 10'h3EE, 2'b11};
      tbl[3] = '{32'h0002_0000, 10'h3BF, 2'b11};
      tbl[4] = '{32'h0000_0020, 10'h3FF, 2'b10};
      tbl[5] = '{32'h0024_0000, 10'h37F, 2'b01};
      tbl[6] = '{32'h001F_001F, 10'h000, 2'b11};

      cyc(2);
      chk("rst_joy", o_joy_n, 10'h3FF);
      chk("rst_start", o_start_n, 2'b11);
      chk("rst_coin", o_coin_n, 2'b11);
      chk("rst_pause", o_pause, 1'b0);
      i_rst = 1'b0;
      cyc(2);

      for (int i = 0; i < 7; i++) begin
         i_joystick = tbl[i].js;
         cyc(1);
         chk($sformatf("vec%0d_joy", i), o_joy_n, tbl[i].joy);
         chk($sformatf("vec%0d_start", i), o_start_n, tbl[i].st);
         chk($sformatf("vec%0d_coin", i), o_coin_n, 2'b11);
      end
      i_joystick = '0;
      cyc(2);

      // key latency and extended-flag match
      key(1, 1, 8'h75); cyc(1);
      chk("key_up_t1", o_joy_n[3], 1'b1);
      cyc(1);
      chk("key_up_t2", o_joy_n[3], 1'b0);
      key(0, 1, 8'h75); cyc(2);
      chk("key_up_rel", o_joy_n[3], 1'b1);
      key(1, 0, 8'h75); cyc(2);
      chk("key_noext", o_joy_n, 10'h3FF);
      key(1, 0, 8'h14); cyc(2);
      chk("key_p1_b0", o_joy_n, 10'h3EF);
      key(0, 0, 8'h14); cyc(2);

      // autofire: half-period of 4 cycles
      i_autofire_en = 1'b1;
      i_joystick[4] = 1'b1;
      cyc(2);
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         s[i] = o_joy_n[4];
      end
      ok = 1'b1; trans = 0;
      for (int i = 0; i < 12; i++) if (s[i+4] == s[i]) ok = 1'b0;
      for (int i = 1; i < 16; i++) if (s[i] != s[i-1]) trans++;
      chk("af_halfperiod", ok, 1'b1);
      chk("af_transitions", (trans >= 3 && trans <= 4), 1'b1);
      i_autofire_en = 1'b0;
      cyc(2);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         if (o_joy_n[4] !== 1'b0) ok = 1'b0;
      end
      chk("af_off_steady", ok, 1'b1);
      i_joystick = '0;
      cyc(2);

      // coin stretcher
      i_joystick[6] = 1'b1;
      coin_run(200, 1'b0, low, pulses);
      chk("coin_held_len", low, CC);
      chk("coin_held_once", pulses, 1);
      i_joystick[6] = 1'b0; cyc(5);
      i_joystick[6] = 1'b1;
      coin_run(40, 1'b0, low, pulses);
      chk("coin_second_len", low, CC);
      chk("coin_second_cnt", pulses, 1);
      i_joystick[6] = 1'b0; cyc(20);
      i_joystick[6] = 1'b1;
      coin_run(60, 1'b1, low, pulses);
      chk("coin_repress_len", low, CC);
      chk("coin_repress_cnt", pulses, 1);
      i_joystick = '0; cyc(20);

      // pause toggle
      key(1, 0, 8'h0C); cyc(2);
      chk("pause_on", o_pause, 1'b1);
      key(0, 0, 8'h0C); cyc(2);
      chk("pause_hold", o_pause, 1'b1);
      key(1, 0, 8'h0C); cyc(2);
      chk("pause_off", o_pause, 1'b0);
      key(0, 0, 8'h0C); cyc(2);
      i_soft_rst = 1'b1; i_joystick[7] = 1'b1; cyc(1);
      chk("pause_clr_wins", o_pause, 1'b0);
      i_soft_rst = 1'b0; cyc(2);
      chk("pause_no_retoggle", o_pause, 1'b0);
      i_joystick = '0; cyc(2);
      i_joystick[23] = 1'b1; cyc(2);
      chk("pause_p2_joy", o_pause, 1'b1);
      i_joystick = '0; i_soft_rst = 1'b1; cyc(1);
      chk("pause_soft_clr", o_pause, 1'b0);
      i_soft_rst = 1'b0; cyc(2);

      // soft reset drops a simultaneous event and clears held keys
      i_soft_rst = 1'b1; key(1, 1, 8'h75); cyc(1);
      i_soft_rst = 1'b0; cyc(2);
      chk("soft_drop_evt", o_joy_n[3], 1'b1);
      key(1, 1, 8'h75); cyc(2);
      chk("soft_pre_held", o_joy_n[3], 1'b0);
      i_soft_rst = 1'b1; cyc(2);
      chk("soft_clears_key", o_joy_n[3], 1'b1);
      i_soft_rst = 1'b0; cyc(2);

      // downloading
      key(1, 0, 8'h34); cyc(2);
      chk("p2_right_key", o_joy_n[5], 1'b0);
      i_downloading = 1'b1; i_joystick = 32'h0001_0021; cyc(1);
      chk("dl_joy", o_joy_n, 10'h3FF);
      chk("dl_start", o_start_n, 2'b11);
      chk("dl_coin", o_coin_n, 2'b11);
      key(1, 1, 8'h75); cyc(2);
      i_downloading = 1'b0; i_joystick = '0; cyc(3);
      chk("dl_keys_cleared", o_joy_n, 10'h3FF);
      key(1, 0, 8'h34); cyc(2);
      chk("dl_new_press", o_joy_n[5], 1'b0);
      key(0, 0, 8'h34); cyc(2);

      // async reset in the middle of a coin pulse
      key(1, 0, 8'h14); i_joystick[6] = 1'b1; cyc(5);
      chk("arst_pre_coin", o_coin_n[0], 1'b0);
      #2 i_rst = 1'b1;
      #1;
      chk("arst_coin", o_coin_n, 2'b11);
      chk("arst_joy", o_joy_n, 10'h3FF);
      cyc(1);
      i_rst = 1'b0; i_joystick = '0; cyc(3);
      chk("arst_after", o_coin_n, 2'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
